// File: rtl/mem_model_if.sv
// Bus bundle for mem_model: read request/response and write request/acknowledge channels.
// The memory side uses the slave modport; the requester uses master.
interface mem_model_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  READ_RECEIVE_VALID;
  logic [ADDR_WIDTH-1:0] READ_RECEIVE_ADDR;
  logic                  READ_RECEIVE_READY;
  logic                  READ_SEND_VALID;
  logic [ADDR_WIDTH-1:0] READ_SEND_ADDR;
  logic [DATA_WIDTH-1:0] READ_SEND_DATA;
  logic                  READ_SEND_READY;
  logic                  WRITE_RECEIVE_VALID;
  logic [ADDR_WIDTH-1:0] WRITE_RECEIVE_ADDR;
  logic [DATA_WIDTH-1:0] WRITE_RECEIVE_DATA;
  logic                  WRITE_RECEIVE_READY;
  logic                  WRITE_SEND_VALID;
  logic [ADDR_WIDTH-1:0] WRITE_SEND_ADDR;
  logic                  WRITE_SEND_READY;

  modport master (
    output READ_RECEIVE_VALID, READ_RECEIVE_ADDR,
    input  READ_RECEIVE_READY,
    input  READ_SEND_VALID, READ_SEND_ADDR, READ_SEND_DATA,
    output READ_SEND_READY,
    output WRITE_RECEIVE_VALID, WRITE_RECEIVE_ADDR, WRITE_RECEIVE_DATA,
    input  WRITE_RECEIVE_READY,
    input  WRITE_SEND_VALID, WRITE_SEND_ADDR,
    output WRITE_SEND_READY
  );

  modport slave (
    input  READ_RECEIVE_VALID, READ_RECEIVE_ADDR,
    output READ_RECEIVE_READY,
    output READ_SEND_VALID, READ_SEND_ADDR, READ_SEND_DATA,
    input  READ_SEND_READY,
    input  WRITE_RECEIVE_VALID, WRITE_RECEIVE_ADDR, WRITE_RECEIVE_DATA,
    output WRITE_RECEIVE_READY,
    output WRITE_SEND_VALID, WRITE_SEND_ADDR,
    input  WRITE_SEND_READY
  );
endinterface

// File: rtl/mem_model.sv
// Behavioural-grade memory model with a latency-shaped read response queue and
// write acknowledges; optional strict read/write alternation.
module mem_model #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 2,
  parameter int QUEUE_DEPTH  = 4,
  parameter int ALTERNATE    = 0
) (
  input  logic       CLK,
  input  logic       RST,
  mem_model_if.slave bus
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] Q_LIMIT = CNT_W'(QUEUE_DEPTH);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(READ_LATENCY);
  localparam logic [0:0] S_READ  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  logic [DATA_WIDTH-1:0] mem_r    [WORDS];
  logic [ADDR_WIDTH-1:0] q_addr_r [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] q_data_r [QUEUE_DEPTH];
  logic [AGE_W-1:0]      q_age_r  [QUEUE_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [0:0]            state_r;
  logic                  ack_valid_r;
  logic [ADDR_WIDTH-1:0] ack_addr_r;

  logic                  head_ok_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  ack_hs_s;
  logic                  wr_acc_s;
  logic                  rd_ready_s;
  logic                  wr_ready_s;
  logic [DEPTH_LOG2-1:0] rd_idx_s;
  logic [DEPTH_LOG2-1:0] wr_idx_s;

  // Handshake qualification and channel readiness.
  always_comb begin
    rd_idx_s  = bus.READ_RECEIVE_ADDR[DEPTH_LOG2-1:0];
    wr_idx_s  = bus.WRITE_RECEIVE_ADDR[DEPTH_LOG2-1:0];
    head_ok_s = (count_r != CNT_W'(0)) && (q_age_r[rd_ptr_r] >= AGE_MAX);
    pop_s     = head_ok_s && bus.READ_SEND_READY;
    ack_hs_s  = ack_valid_r && bus.WRITE_SEND_READY;
    rd_ready_s = 1'b0;
    wr_ready_s = 1'b0;
    if (RST) begin
      rd_ready_s = 1'b0;
      wr_ready_s = 1'b0;
    end else if (ALTERNATE != 0) begin
      // One read in flight at a time, and no same-cycle refill, so the phases never overlap.
      rd_ready_s = (state_r == S_READ) && (count_r == CNT_W'(0));
      wr_ready_s = (state_r == S_WRITE) && !ack_valid_r;
    end else begin
      rd_ready_s = (count_r < Q_LIMIT) || ((count_r == Q_LIMIT) && pop_s);
      wr_ready_s = !ack_valid_r || ack_hs_s;
    end
    push_s   = rd_ready_s && bus.READ_RECEIVE_VALID;
    wr_acc_s = wr_ready_s && bus.WRITE_RECEIVE_VALID;
  end

  assign bus.READ_RECEIVE_READY  = rd_ready_s;
  assign bus.READ_SEND_VALID     = head_ok_s;
  assign bus.READ_SEND_ADDR      = q_addr_r[rd_ptr_r];
  assign bus.READ_SEND_DATA      = q_data_r[rd_ptr_r];
  assign bus.WRITE_RECEIVE_READY = wr_ready_s;
  assign bus.WRITE_SEND_VALID    = ack_valid_r;
  assign bus.WRITE_SEND_ADDR     = ack_addr_r;

  // Storage and queue payload; a read captures pre-write data in its accept cycle.
  always_ff @(posedge CLK) begin
    if (wr_acc_s) begin
      mem_r[wr_idx_s] <= bus.WRITE_RECEIVE_DATA;
    end
    if (push_s) begin
      q_addr_r[wr_ptr_r] <= bus.READ_RECEIVE_ADDR;
      q_data_r[wr_ptr_r] <= mem_r[rd_idx_s];
    end
  end

  // Queue pointers, occupancy and saturating per-entry age.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_age_r[i] <= {AGE_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (q_age_r[i] < AGE_MAX) begin
          q_age_r[i] <= q_age_r[i] + AGE_W'(1);
        end
      end
      // A fresh entry counts its accept cycle, so it matures exactly READ_LATENCY cycles later.
      if (push_s) begin
        q_age_r[wr_ptr_r] <= AGE_W'(1);
        wr_ptr_r          <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Write acknowledge holding register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ack_valid_r <= 1'b0;
      ack_addr_r  <= {ADDR_WIDTH{1'b0}};
    end else if (wr_acc_s) begin
      ack_valid_r <= 1'b1;
      ack_addr_r  <= bus.WRITE_RECEIVE_ADDR;
    end else if (ack_hs_s) begin
      ack_valid_r <= 1'b0;
    end
  end

  // Read/write alternation phase; parked in S_READ when alternation is off.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_READ;
    end else if (ALTERNATE == 0) begin
      state_r <= S_READ;
    end else begin
      case (state_r)
        S_READ:  state_r <= pop_s ? S_WRITE : S_READ;
        S_WRITE: state_r <= ack_hs_s ? S_READ : S_WRITE;
        default: state_r <= S_READ;
      endcase
    end
  end

endmodule

// File: doc/mem_model.md
MEM_MODEL -- requirements
Module: mem_model

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width in bits.
REQ-003 SHALL have parameter DEPTH_LOG2, default 10, log2 of storage words; 1..ADDR_WIDTH.
REQ-004 SHALL have parameter READ_LATENCY, default 2, minimum cycles from read accept to response valid; >=1.
REQ-005 SHALL have parameter QUEUE_DEPTH, default 4, max outstanding reads; power of two, >=2.
REQ-006 SHALL have parameter ALTERNATE, default 0; 1 enforces strict read/write alternation.
REQ-007 SHALL have port CLK  input  1  sole clock; all logic on rising edge.
REQ-008 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-009 SHALL have ports READ_RECEIVE_VALID in 1, READ_RECEIVE_ADDR in ADDR_WIDTH, READ_RECEIVE_READY out 1: read request channel.
REQ-010 SHALL have ports READ_SEND_VALID out 1, READ_SEND_ADDR out ADDR_WIDTH, READ_SEND_DATA out DATA_WIDTH, READ_SEND_READY in 1: read response channel.
REQ-011 SHALL have ports WRITE_RECEIVE_VALID in 1, WRITE_RECEIVE_ADDR in ADDR_WIDTH, WRITE_RECEIVE_DATA in DATA_WIDTH, WRITE_RECEIVE_READY out 1: write request channel.
REQ-012 SHALL have ports WRITE_SEND_VALID out 1, WRITE_SEND_ADDR out ADDR_WIDTH, WRITE_SEND_READY in 1: write acknowledge channel.

Function
REQ-013 SHALL transfer on any channel only in a cycle where VALID and READY are both high.
REQ-014 SHALL store 2^DEPTH_LOG2 words indexed by ADDR[DEPTH_LOG2-1:0]; upper address bits ignored for indexing but echoed unmodified on responses.
REQ-015 SHALL capture read data from storage in the accept cycle into a FIFO entry {addr, data, age counter}.
REQ-016 SHALL assert READ_RECEIVE_READY when queue count < QUEUE_DEPTH, or count == QUEUE_DEPTH with a response handshake this cycle (and state permits, REQ-022).
REQ-017 SHALL assert READ_SEND_VALID only when queue non-empty and head entry accepted >= READ_LATENCY cycles ago; read accepted at cycle t -> earliest VALID at t+READ_LATENCY.
REQ-018 SHALL return responses in acceptance order; READ_SEND_ADDR/DATA hold stable while VALID high and READY low.
REQ-019 SHALL commit write data to storage at end of accept cycle; a read accepted in the same cycle to the same index returns old data; a read accepted in a later cycle returns new data.
REQ-020 SHALL raise WRITE_SEND_VALID the cycle after a write accept, WRITE_SEND_ADDR = accepted address, held until WRITE_SEND_READY.
REQ-021 SHALL assert WRITE_RECEIVE_READY when no ack pending, or ack handshaking this cycle (and state permits); back-to-back writes sustain one per cycle with READY tied high.
REQ-022 With ALTERNATE=1, SHALL run state machine S_READ/S_WRITE: S_READ permits read accepts only, goes to S_WRITE on a read response handshake; S_WRITE permits write accepts only, goes to S_READ on a write ack handshake; queue limited to one outstanding read.
REQ-023 With ALTERNATE=0, SHALL accept reads and writes concurrently and independently; state machine held in S_READ.
REQ-024 SHALL permit simultaneous push and pop on a full queue with count unchanged; age counters saturate at READ_LATENCY.

Reset
REQ-025 SHALL on RST clear READ_SEND_VALID, WRITE_SEND_VALID, queue count, pointers and age counters to 0, state to S_READ, within the cycle RST is sampled high.
REQ-026 SHALL discard outstanding reads and pending acks on RST mid-operation; no response issued afterwards for them.
REQ-027 SHALL keep storage contents unchanged by RST; READY outputs deasserted while RST high.

Verification
REQ-028 Write addr 0x10 data 0xCAFEF00D, then read 0x10 -> ack with addr 0x10 next cycle; read response data 0xCAFEF00D exactly READ_LATENCY cycles after accept.
REQ-029 READ_SEND_READY low, issue 5 reads (QUEUE_DEPTH=4) -> 4 accepted, READ_RECEIVE_READY low; raise READY -> 4 responses in order, 5th accepted same cycle as first pop.
REQ-030 Same-cycle write 0x5 data 0x1 and read 0x5 (old 0x0) -> read returns 0x0; next read returns 0x1.
REQ-031 ALTERNATE=1, drive two reads back-to-back -> second held until a write ack completes; state sequence S_READ,S_WRITE,S_READ.
REQ-032 RST asserted with 3 reads outstanding -> no READ_SEND_VALID after reset; prior written data still readable.
REQ-033 DEPTH_LOG2=4, write addr 0x13 data 0xAA, read 0x3 -> data 0xAA, response addr 0x3.
